// File: rtl/video_timing_pattern.sv
// Raster timing generator with a selectable RGB test pattern for a TMDS transmitter.
// Every output is registered and describes the pixel addressed by the counters one edge earlier.
`timescale 1ns/1ps
module video_timing_pattern #(
  parameter int unsigned NumColActive   = 640,
  parameter int unsigned NumColFront    = 16,
  parameter int unsigned NumColSync     = 96,
  parameter int unsigned NumColBack     = 48,
  parameter int unsigned NumRowActive   = 480,
  parameter int unsigned NumRowFront    = 10,
  parameter int unsigned NumRowSync     = 2,
  parameter int unsigned NumRowBack     = 33,
  parameter logic        SyncActiveHigh = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] mode_i,
  output logic       de_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic [9:0] x_o,
  output logic [9:0] y_o,
  output logic       sof_o,
  output logic [7:0] red_o,
  output logic [7:0] grn_o,
  output logic [7:0] blu_o
);

  localparam int unsigned ColTotal = NumColActive + NumColFront + NumColSync + NumColBack;
  localparam int unsigned RowTotal = NumRowActive + NumRowFront + NumRowSync + NumRowBack;
  localparam int unsigned BarWidth = NumColActive / 8;

  localparam logic [9:0]  ColLast  = 10'(ColTotal - 1);
  localparam logic [9:0]  RowLast  = 10'(RowTotal - 1);
  localparam logic [9:0]  BarLast  = 10'(BarWidth - 1);
  localparam logic [10:0] ColAct   = 11'(NumColActive);
  localparam logic [10:0] RowAct   = 11'(NumRowActive);
  localparam logic [10:0] HsStart  = 11'(NumColActive + NumColFront);
  localparam logic [10:0] HsEnd    = 11'(NumColActive + NumColFront + NumColSync);
  localparam logic [10:0] VsStart  = 11'(NumRowActive + NumRowFront);
  localparam logic [10:0] VsEnd    = 11'(NumRowActive + NumRowFront + NumRowSync);

  if ((ColTotal > 1024) || (RowTotal > 1024)) begin : g_bad_totals
    $error("video_timing_pattern: ColTotal and RowTotal must not exceed 1024");
  end
  if (((NumColActive % 8) != 0) || (NumColActive == 0)) begin : g_bad_active
    $error("video_timing_pattern: NumColActive must be a non-zero multiple of 8");
  end

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      3'd7:    c = 24'h000000;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  logic [9:0]  col_r, row_r, col_nxt_s, row_nxt_s;
  logic [2:0]  bar_idx_r, bar_idx_nxt_s;
  logic [9:0]  bar_pos_r, bar_pos_nxt_s;
  logic [1:0]  mode_r, mode_eff_s;
  logic [7:0]  frame_r, frame_eff_s;
  logic [10:0] col_ext_s, row_ext_s;
  logic        origin_s, de_s, hs_on_s, vs_on_s;
  logic [23:0] rgb_s;

  // Raster counter advance: column wraps at the line end, row wraps at the frame end.
  always_comb begin
    col_nxt_s = col_r + 10'd1;
    row_nxt_s = row_r;
    if (col_r == ColLast) begin
      col_nxt_s = 10'd0;
      if (row_r == RowLast) begin
        row_nxt_s = 10'd0;
      end else begin
        row_nxt_s = row_r + 10'd1;
      end
    end else begin
      row_nxt_s = row_r;
    end
  end

  // Bar index steps every BarWidth columns, restarting with each line so no divider is needed.
  always_comb begin
    bar_idx_nxt_s = bar_idx_r;
    bar_pos_nxt_s = bar_pos_r + 10'd1;
    if (col_r == ColLast) begin
      bar_idx_nxt_s = 3'd0;
      bar_pos_nxt_s = 10'd0;
    end else if (bar_pos_r == BarLast) begin
      bar_idx_nxt_s = bar_idx_r + 3'd1;
      bar_pos_nxt_s = 10'd0;
    end else begin
      bar_idx_nxt_s = bar_idx_r;
    end
  end

  // Region decode; at the frame origin the freshly sampled mode and next frame count apply at once.
  always_comb begin
    col_ext_s   = {1'b0, col_r};
    row_ext_s   = {1'b0, row_r};
    origin_s    = (col_r == 10'd0) && (row_r == 10'd0);
    de_s        = (col_ext_s < ColAct) && (row_ext_s < RowAct);
    hs_on_s     = (col_ext_s >= HsStart) && (col_ext_s < HsEnd);
    vs_on_s     = (row_ext_s >= VsStart) && (row_ext_s < VsEnd);
    mode_eff_s  = origin_s ? mode_i : mode_r;
    frame_eff_s = origin_s ? (frame_r + 8'd1) : frame_r;
  end

  // Test pattern selection, blanked outside the active region.
  always_comb begin
    rgb_s = 24'h000000;
    if (de_s) begin
      case (mode_eff_s)
        2'd0:    rgb_s = bar_colour(bar_idx_r);
        2'd1:    rgb_s = {col_r[9:2], col_r[9:2], col_r[9:2]};
        2'd2:    rgb_s = (col_r[5] ^ row_r[5]) ? 24'hFFFFFF : 24'h000000;
        2'd3:    rgb_s = {frame_eff_s, 8'h00, ~frame_eff_s};
        default: rgb_s = 24'h000000;
      endcase
    end else begin
      rgb_s = 24'h000000;
    end
  end

  // Counter, mode and frame state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_r     <= 10'd0;
      row_r     <= 10'd0;
      bar_idx_r <= 3'd0;
      bar_pos_r <= 10'd0;
      mode_r    <= 2'd0;
      frame_r   <= 8'd0;
    end else begin
      col_r     <= col_nxt_s;
      row_r     <= row_nxt_s;
      bar_idx_r <= bar_idx_nxt_s;
      bar_pos_r <= bar_pos_nxt_s;
      mode_r    <= mode_eff_s;
      frame_r   <= frame_eff_s;
    end
  end

  // Output registers, all describing the same pixel.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      de_o    <= 1'b0;
      hsync_o <= ~SyncActiveHigh;
      vsync_o <= ~SyncActiveHigh;
      x_o     <= 10'd0;
      y_o     <= 10'd0;
      sof_o   <= 1'b0;
      red_o   <= 8'h00;
      grn_o   <= 8'h00;
      blu_o   <= 8'h00;
    end else begin
      de_o    <= de_s;
      hsync_o <= hs_on_s ? SyncActiveHigh : ~SyncActiveHigh;
      vsync_o <= vs_on_s ? SyncActiveHigh : ~SyncActiveHigh;
      x_o     <= col_r;
      y_o     <= row_r;
      sof_o   <= origin_s;
      red_o   <= rgb_s[23:16];
      grn_o   <= rgb_s[15:8];
      blu_o   <= rgb_s[7:0];
    end
  end

endmodule

// File: tb/tb_video_timing_pattern.sv
// Bench for video_timing_pattern: two reduced rasters checked every cycle against a
// pixel-index model, plus literal spot checks of timing, bars, mode switch, frame wrap and reset.
`timescale 1ns/1ps
module tb_video_timing_pattern;

  localparam int A_CA = 64, A_CF = 4, A_CS = 8, A_CB = 4;
  localparam int A_RA = 40, A_RF = 2, A_RS = 3, A_RB = 3;
  localparam int A_CT = A_CA + A_CF + A_CS + A_CB;
  localparam int A_FT = A_CT * (A_RA + A_RF + A_RS + A_RB);
  localparam int B_CA = 16, B_CF = 2, B_CS = 3, B_CB = 3;
  localparam int B_RA = 6, B_RF = 1, B_RS = 2, B_RB = 1;
  localparam int B_CT = B_CA + B_CF + B_CS + B_CB;
  localparam int B_FT = B_CT * (B_RA + B_RF + B_RS + B_RB);

  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic       sof;
    logic [9:0] x;
    logic [9:0] y;
    logic [23:0] rgb;
  } px_t;

  logic clk, rst_n;
  logic [1:0] mode_a, mode_b;
  logic de_a, hs_a, vs_a, sof_a, de_b, hs_b, vs_b, sof_b;
  logic [9:0] x_a, y_a, x_b, y_b;
  logic [7:0] red_a, grn_a, blu_a, red_b, grn_b, blu_b;
  px_t act_a, act_b, exp_a, exp_b;
  int idx_a, idx_b;
  logic [1:0] mode_ma, mode_mb;
  logic [7:0] frame_ma, frame_mb;
  int total, bad, b_sofs;

  video_timing_pattern #(
    .NumColActive(A_CA), .NumColFront(A_CF), .NumColSync(A_CS), .NumColBack(A_CB),
    .NumRowActive(A_RA), .NumRowFront(A_RF), .NumRowSync(A_RS), .NumRowBack(A_RB),
    .SyncActiveHigh(1'b0)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .mode_i(mode_a), .de_o(de_a), .hsync_o(hs_a),
    .vsync_o(vs_a), .x_o(x_a), .y_o(y_a), .sof_o(sof_a), .red_o(red_a),
    .grn_o(grn_a), .blu_o(blu_a)
  );

  video_timing_pattern #(
    .NumColActive(B_CA), .NumColFront(B_CF), .NumColSync(B_CS), .NumColBack(B_CB),
    .NumRowActive(B_RA), .NumRowFront(B_RF), .NumRowSync(B_RS), .NumRowBack(B_RB),
    .SyncActiveHigh(1'b1)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .mode_i(mode_b), .de_o(de_b), .hsync_o(hs_b),
    .vsync_o(vs_b), .x_o(x_b), .y_o(y_b), .sof_o(sof_b), .red_o(red_b),
    .grn_o(grn_b), .blu_o(blu_b)
  );

  assign act_a = {de_a, hs_a, vs_a, sof_a, x_a, y_a, red_a, grn_a, blu_a};
  assign act_b = {de_b, hs_b, vs_b, sof_b, x_b, y_b, red_b, grn_b, blu_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected pixel purely from its linear index within the frame.
  function automatic px_t model_px(input int ca, input int cf, input int cs, input int ct,
                                   input int ra, input int rf, input int rs, input logic pol,
                                   input int idx, input logic [1:0] mode, input logic [7:0] frame);
    px_t p;
    int col, row;
    logic [23:0] bars [8];
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    col   = idx % ct;
    row   = idx / ct;
    p.x   = 10'(col);
    p.y   = 10'(row);
    p.sof = (idx == 0);
    p.de  = (col < ca) && (row < ra);
    p.hs  = ((col >= ca + cf) && (col < ca + cf + cs)) ? pol : ~pol;
    p.vs  = ((row >= ra + rf) && (row < ra + rf + rs)) ? pol : ~pol;
    p.rgb = 24'h000000;
    if (p.de) begin
      case (mode)
        2'd0: p.rgb = bars[col / (ca / 8)];
        2'd1: p.rgb = {3{8'(col / 4)}};
        2'd2: p.rgb = ((((col / 32) % 2) ^ ((row / 32) % 2)) == 1) ? 24'hFFFFFF : 24'h000000;
        default: p.rgb = {frame, 8'h00, ~frame};
      endcase
    end
    return p;
  endfunction

  function automatic px_t reset_px(input logic pol);
    return {1'b0, ~pol, ~pol, 1'b0, 10'd0, 10'd0, 24'h000000};
  endfunction

  // Reference raster for instance A: pixel index, per-frame mode and frame number.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_a <= 0; mode_ma <= 2'd0; frame_ma <= 8'd0; exp_a <= reset_px(1'b0);
    end else begin
      idx_a    <= (idx_a + 1) % A_FT;
      mode_ma  <= (idx_a == 0) ? mode_a : mode_ma;
      frame_ma <= (idx_a == 0) ? frame_ma + 8'd1 : frame_ma;
      exp_a    <= model_px(A_CA, A_CF, A_CS, A_CT, A_RA, A_RF, A_RS, 1'b0, idx_a,
                           (idx_a == 0) ? mode_a : mode_ma,
                           (idx_a == 0) ? frame_ma + 8'd1 : frame_ma);
    end
  end

  // Reference raster for instance B.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_b <= 0; mode_mb <= 2'd0; frame_mb <= 8'd0; exp_b <= reset_px(1'b1);
    end else begin
      idx_b    <= (idx_b + 1) % B_FT;
      mode_mb  <= (idx_b == 0) ? mode_b : mode_mb;
      frame_mb <= (idx_b == 0) ? frame_mb + 8'd1 : frame_mb;
      exp_b    <= model_px(B_CA, B_CF, B_CS, B_CT, B_RA, B_RF, B_RS, 1'b1, idx_b,
                           (idx_b == 0) ? mode_b : mode_mb,
                           (idx_b == 0) ? frame_mb + 8'd1 : frame_mb);
    end
  end

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  task automatic wait_px_a(input int x, input int y);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((x_a == 10'(x)) && (y_a == 10'(y))) && (n < 2 * A_FT));
    if (!((x_a == 10'(x)) && (y_a == 10'(y)))) begin
      total++;
      bad++;
      $display("FAIL wait_a: pixel (%0d,%0d) not reached, got (%0d,%0d)", x, y, x_a, y_a);
    end
  endtask

  initial begin
    int cnt_de, cnt_hs, first_hs, cnt_vs, cnt_de_blank, cnt_sof, n;
    total = 0; bad = 0; b_sofs = 0;
    rst_n = 1'b0; mode_a = 2'd0; mode_b = 2'd3;

    fork
      forever begin
        @(negedge clk);
        check("a_px", act_a, exp_a);
        check("b_px", act_b, exp_b);
      end
      forever begin
        @(negedge clk);
        if (rst_n && sof_b) begin
          b_sofs++;
          if (b_sofs == 255) check("b_frame255", {red_b, blu_b}, 16'hFF00);
          if (b_sofs == 256) check("b_frame256", {red_b, blu_b}, 16'h00FF);
          if (b_sofs == 257) check("b_frame257", {red_b, blu_b}, 16'h01FE);
        end
      end
    join_none

    repeat (3) @(negedge clk);
    check("a_reset", act_a, {1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 24'h000000});
    check("b_reset", act_b, 48'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("a_first", act_a, {1'b1, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 24'hFFFFFF});
    check("b_first", act_b, {1'b1, 1'b0, 1'b0, 1'b1, 10'd0, 10'd0, 24'h0100FE});

    wait_px_a(7, 0);  check("bar_x7",  {de_a, red_a, grn_a, blu_a}, {1'b1, 24'hFFFFFF});
    wait_px_a(8, 0);  check("bar_x8",  {de_a, red_a, grn_a, blu_a}, {1'b1, 24'hFFFF00});
    wait_px_a(39, 0); check("bar_x39", {de_a, red_a, grn_a, blu_a}, {1'b1, 24'hFF00FF});
    wait_px_a(40, 0); check("bar_x40", {de_a, red_a, grn_a, blu_a}, {1'b1, 24'hFF0000});
    wait_px_a(63, 0); check("bar_x63", {de_a, red_a, grn_a, blu_a}, {1'b1, 24'h000000});
    wait_px_a(64, 0); check("bar_x64", {de_a, red_a, grn_a, blu_a}, {1'b0, 24'h000000});

    wait_px_a(0, 1);
    cnt_de = 0; cnt_hs = 0; first_hs = -1;
    for (int i = 0; i < A_CT; i++) begin
      if (de_a) cnt_de++;
      if (!hs_a) begin
        cnt_hs++;
        if (first_hs < 0) first_hs = int'(x_a);
      end
      @(negedge clk);
    end
    check("line_de", 48'(cnt_de), 48'd64);
    check("line_hs_len", 48'(cnt_hs), 48'd8);
    check("line_hs_start", 48'(first_hs), 48'd68);
    check("line_period", {x_a, y_a}, {10'd0, 10'd2});

    wait_px_a(30, 10);
    mode_a = 2'd2;
    wait_px_a(8, 20);  check("mode_hold", {red_a, grn_a, blu_a}, 24'hFFFF00);
    wait_px_a(0, 0);   check("chk_00",   {sof_a, red_a, grn_a, blu_a}, {1'b1, 24'h000000});
    wait_px_a(32, 0);  check("chk_32_0", {red_a, grn_a, blu_a}, 24'hFFFFFF);
    wait_px_a(0, 32);  check("chk_0_32", {red_a, grn_a, blu_a}, 24'hFFFFFF);
    wait_px_a(32, 32); check("chk_32_32", {red_a, grn_a, blu_a}, 24'h000000);

    wait_px_a(0, 0);
    cnt_vs = 0; cnt_de = 0; cnt_de_blank = 0; cnt_sof = 0;
    for (int i = 0; i < A_FT; i++) begin
      if (!vs_a) cnt_vs++;
      if (de_a) cnt_de++;
      if (de_a && (y_a >= 10'd40)) cnt_de_blank++;
      if (sof_a) cnt_sof++;
      @(negedge clk);
    end
    check("frame_vs", 48'(cnt_vs), 48'd240);
    check("frame_de", 48'(cnt_de), 48'd2560);
    check("frame_de_blank", 48'(cnt_de_blank), 48'd0);
    check("frame_sof_cnt", 48'(cnt_sof), 48'd1);
    check("frame_period", {sof_a, x_a, y_a}, {1'b1, 10'd0, 10'd0});

    n = 0;
    while ((b_sofs < 257) && (n < 70000)) begin
      mode_a = 2'($urandom_range(0, 3));
      @(negedge clk);
      n++;
    end
    if (b_sofs < 257) begin
      total++;
      bad++;
      $display("FAIL b_wrap: only %0d frames seen", b_sofs);
    end

    wait_px_a(20, 10);
    #2 rst_n = 1'b0;
    #1;
    check("a_midreset", act_a, {1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 24'h000000});
    check("b_midreset", act_b, 48'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("a_restart", {sof_a, de_a, x_a, y_a}, {1'b1, 1'b1, 10'd0, 10'd0});

    for (int i = 0; i < 300; i++) begin
      mode_a = 2'($urandom_range(0, 3));
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
